// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and default parameter values for the PC unit.
`default_nettype none

package pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

  // Encoded so that a numerically larger value wins arbitration.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_RET  = 3'd1,
    SRC_JMP  = 3'd2,
    SRC_BR   = 3'd3,
    SRC_TRAP = 3'd4
  } redir_src_e;

  localparam int          DEF_XLEN      = 32;
  localparam int          DEF_INC       = 4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;
  localparam int          DEF_RAS_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
`default_nettype none

module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            push_data,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] stack [DEPTH];
  logic [PW-1:0]   top_ptr;
  logic            do_pop;

  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign top    = stack[top_ptr];
  assign do_pop = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && do_pop) begin
      // Pop-then-push collapses into an in-place rewrite of the top slot.
      stack[top_ptr] <= push_data;
    end else if (push) begin
      stack[top_ptr + PW'(1)] <= push_data;
      top_ptr <= top_ptr + PW'(1);
      if (!full) count <= count + (PW+1)'(1);
    end else if (do_pop) begin
      top_ptr <= top_ptr - PW'(1);
      count   <= count - (PW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// pc_unit: fetch PC generator with prioritized redirects, stall-time pending
// redirect capture, misalignment trapping and a return-address stack.
`default_nettype none

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter int              INC       = DEF_INC,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            trap,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            call,
  input  logic [XLEN-1:0] call_ret_addr,
  input  logic            ret,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            redirect_pend,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_uflow,
  output logic            misalign
);

  pc_state_e                  state, state_nxt;
  redir_src_e                 cand_src, pend_src;
  logic [XLEN-1:0]            cand_tgt, cand_fix, pend_tgt, ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic                       ret_hit, cand_bad, accept;

  assign ret_hit = ret && (ras_count != '0);

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (trap),
    .push      (call),
    .pop       (ret_hit),
    .push_data (call_ret_addr),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_comb begin
    cand_src = SRC_NONE;
    cand_tgt = '0;
    if (trap) begin
      cand_src = SRC_TRAP;
      cand_tgt = TRAP_VEC;
    end else if (br_taken) begin
      cand_src = SRC_BR;
      cand_tgt = br_target;
    end else if (jmp) begin
      cand_src = SRC_JMP;
      cand_tgt = jmp_target;
    end else if (ret_hit) begin
      cand_src = SRC_RET;
      cand_tgt = ras_top;
    end
    cand_bad = (cand_src != SRC_NONE) && ((cand_tgt % XLEN'(INC)) != '0);
    cand_fix = cand_bad ? TRAP_VEC : cand_tgt;
    // While stalled, a pending redirect yields only to equal or higher priority.
    accept   = (cand_src != SRC_NONE) &&
               (!stall || !redirect_pend || (cand_src >= pend_src));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_valid  = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        pc_valid = 1'b1;
        if (stall) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        pc_valid = 1'b1;
        if (!stall) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out        <= RESET_VEC;
      redirect_pend <= 1'b0;
      pend_src      <= SRC_NONE;
      pend_tgt      <= '0;
      misalign      <= 1'b0;
      ras_uflow     <= 1'b0;
    end else begin
      misalign  <= accept && cand_bad;
      ras_uflow <= ret && ras_empty;
      if (stall) begin
        if (accept) begin
          redirect_pend <= 1'b1;
          pend_src      <= cand_src;
          pend_tgt      <= cand_fix;
        end
      end else begin
        redirect_pend <= 1'b0;
        pend_src      <= SRC_NONE;
        if (cand_src != SRC_NONE) pc_out <= cand_fix;
        else if (redirect_pend)   pc_out <= pend_tgt;
        else                      pc_out <= pc_out + XLEN'(INC);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized traffic checked against a queue-based reference model.
`default_nettype none

module tb_pc_unit;

  localparam logic [31:0] TRAP_V = 32'h80;

  logic        clk, rst_n, stall, trap, br_taken, jmp, call, ret;
  logic [31:0] br_target, jmp_target, call_ret_addr;
  logic [31:0] pc_out;
  logic        pc_valid, redirect_pend, ras_empty, ras_full, ras_uflow, misalign;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_pend_tgt;
  logic [31:0] m_ras[$];
  bit          m_boot, m_pend, m_uflow, m_mis;
  int          m_pend_pri;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .trap(trap),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .call(call), .call_ret_addr(call_ret_addr), .ret(ret),
    .pc_out(pc_out), .pc_valid(pc_valid), .redirect_pend(redirect_pend),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_uflow(ras_uflow), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_boot = 1; m_pend = 0; m_pend_pri = 0; m_pend_tgt = 0;
    m_uflow = 0; m_mis = 0;
    m_ras.delete();
  endtask

  // One clock edge of the reference model, applied with the current inputs.
  task automatic model_edge();
    int          pri;
    logic [31:0] tgt;
    bit          bad, acc, has_top;
    has_top = (m_ras.size() > 0);
    pri = 0; tgt = 0;
    if (trap)                begin pri = 4; tgt = TRAP_V; end
    else if (br_taken)       begin pri = 3; tgt = br_target; end
    else if (jmp)            begin pri = 2; tgt = jmp_target; end
    else if (ret && has_top) begin pri = 1; tgt = m_ras[$]; end
    bad = (pri > 0) && (tgt % 4 != 0);
    if (bad) tgt = TRAP_V;
    acc = (pri > 0) && (!stall || !m_pend || pri >= m_pend_pri);
    m_mis   = acc && bad;
    m_uflow = ret && !has_top;
    if (trap) m_ras.delete();
    else if (ret && has_top && call) m_ras[m_ras.size()-1] = call_ret_addr;
    else if (ret && has_top) void'(m_ras.pop_back());
    else if (call) begin
      m_ras.push_back(call_ret_addr);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
    if (stall) begin
      if (acc) begin m_pend = 1; m_pend_pri = pri; m_pend_tgt = tgt; end
    end else begin
      if (pri > 0)     m_pc = tgt;
      else if (m_pend) m_pc = m_pend_tgt;
      else             m_pc = m_pc + 32'd4;
      m_pend = 0; m_pend_pri = 0;
    end
    m_boot = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc_out,                    m_pc);
    check({tag, ".valid"}, 32'(pc_valid),             32'(!m_boot));
    check({tag, ".pend"},  32'(redirect_pend),        32'(m_pend));
    check({tag, ".empty"}, 32'(ras_empty),            32'(m_ras.size() == 0));
    check({tag, ".full"},  32'(ras_full),             32'(m_ras.size() == 4));
    check({tag, ".uflow"}, 32'(ras_uflow),            32'(m_uflow));
    check({tag, ".mis"},   32'(misalign),             32'(m_mis));
  endtask

  task automatic idle();
    stall = 0; trap = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
    br_target = 0; jmp_target = 0; call_ret_addr = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.pc_const", pc_out, 32'h0);
    rst_n = 1;
    #1;
    check("boot.valid", 32'(pc_valid), 32'h0);

    // Sequential fetch out of BOOT
    step("seq1"); check("seq1.pc_const", pc_out, 32'h4);
    step("seq2"); check("seq2.pc_const", pc_out, 32'h8);
    step("seq3"); check("seq3.pc_const", pc_out, 32'hC);

    // Stalled redirects: JMP, then higher BR replaces it, then lower JMP does not
    stall = 1; jmp = 1; jmp_target = 32'h100;
    step("st_jmp");
    jmp = 0; br_taken = 1; br_target = 32'h200;
    step("st_br");
    br_taken = 0; jmp = 1; jmp_target = 32'h300;
    step("st_jmp2");
    check("st.hold_pc", pc_out, 32'hC);
    check("st.pend", 32'(redirect_pend), 32'h1);
    idle();
    step("st_rel");
    check("st.rel_pc", pc_out, 32'h200);

    // TRAP beats BR and clears the RAS
    call = 1; call_ret_addr = 32'h44;
    step("pre_trap_call");
    idle(); br_taken = 1; br_target = 32'h40; trap = 1;
    step("trap");
    check("trap.pc_const", pc_out, 32'h80);
    check("trap.empty", 32'(ras_empty), 32'h1);

    // RAS overflow then underflow
    idle();
    for (int i = 1; i <= 5; i++) begin
      call = 1; call_ret_addr = 32'(i * 16);
      step("call");
    end
    check("call.full", 32'(ras_full), 32'h1);
    idle(); ret = 1;
    for (int i = 0; i < 4; i++) begin
      step("ret");
      check("ret.pc_const", pc_out, 32'(80 - 16 * i));
    end
    step("ret5");
    check("ret5.pc_const", pc_out, 32'h24);
    check("ret5.uflow", 32'(ras_uflow), 32'h1);

    // Misaligned jump target
    idle(); jmp = 1; jmp_target = 32'h102;
    step("mis");
    check("mis.pc_const", pc_out, 32'h80);
    check("mis.pulse", 32'(misalign), 32'h1);
    idle();
    step("mis_clr");

    // Async reset while a redirect is pending
    stall = 1; jmp = 1; jmp_target = 32'h100; call = 1; call_ret_addr = 32'h500;
    step("pre_rst");
    check("pre_rst.pend", 32'(redirect_pend), 32'h1);
    #2;
    rst_n = 0;
    #1;
    check("arst.pc", pc_out, 32'h0);
    check("arst.pend", 32'(redirect_pend), 32'h0);
    check("arst.empty", 32'(ras_empty), 32'h1);
    model_reset();
    idle();
    @(posedge clk);
    #1;
    rst_n = 1;
    check_all("arst_hold");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      stall         = ($urandom % 4) == 0;
      trap          = ($urandom % 20) == 0;
      br_taken      = ($urandom % 8) == 0;
      jmp           = ($urandom % 8) == 0;
      call          = ($urandom % 4) == 0;
      ret           = ($urandom % 4) == 0;
      br_target     = $urandom & 32'hFFFF_FFFC;
      jmp_target    = $urandom & 32'hFFFF_FFFC;
      call_ret_addr = $urandom & 32'hFFFF_FFFC;
      if (($urandom % 10) == 0) br_target  = br_target  | 32'(1 + $urandom % 3);
      if (($urandom % 10) == 0) jmp_target = jmp_target | 32'(1 + $urandom % 3);
      if (($urandom % 10) == 0) call_ret_addr = call_ret_addr | 32'h2;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
